// File: rtl/bram_stream_reader.sv
// Reads LEN contiguous words from a one-cycle-latency block RAM port and streams
// them out over valid/ready, using a credit scheme so the 4-entry FIFO never overflows.
module bram_stream_reader #(
  parameter int DATA_WIDTH = 72,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   len,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic                  bram_wr,
  output logic [DATA_WIDTH-1:0] bram_din,
  input  logic [DATA_WIDTH-1:0] bram_dout,
  output logic [DATA_WIDTH-1:0] m_tdata,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic                  m_tlast
);

  // Stream handshake: a beat transfers on a rising clk edge where m_tvalid and
  // m_tready are both 1; once m_tvalid rises, m_tdata/m_tlast hold until that edge.

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic [ADDR_WIDTH:0] ONE          = 1;
  localparam logic [2:0]          CREDITS_INIT = 3'd4;

  state_t                  state, state_next;
  logic [ADDR_WIDTH-1:0]   base_q;
  logic [ADDR_WIDTH:0]     len_q;
  logic [ADDR_WIDTH:0]     issued_cnt;
  logic [ADDR_WIDTH:0]     out_cnt;
  logic [2:0]              credits;
  logic [1:0]              tag_pipe;
  logic [DATA_WIDTH-1:0]   fifo_mem [4];
  logic [1:0]              wr_ptr, rd_ptr;
  logic [2:0]              fifo_cnt;
  logic                    done_q;

  logic start_ok, issue, hs, last_hs, fifo_wr;

  assign start_ok = (state == IDLE) && start && (len != '0);
  assign issue    = start_ok ||
                    ((state == RUN) && (issued_cnt < len_q) && (credits != 3'd0));
  assign hs       = m_tvalid && m_tready;
  assign last_hs  = hs && m_tlast;
  assign fifo_wr  = tag_pipe[1];

  assign busy     = (state == RUN);
  assign done     = done_q;
  assign bram_wr  = 1'b0;
  assign bram_din = '0;
  assign m_tvalid = (fifo_cnt != 3'd0);
  assign m_tdata  = fifo_mem[rd_ptr];
  assign m_tlast  = m_tvalid && (out_cnt == (len_q - ONE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_ok) state_next = RUN;
      RUN:     if (last_hs)  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q     <= '0;
      len_q      <= '0;
      issued_cnt <= '0;
      out_cnt    <= '0;
      credits    <= '0;
      tag_pipe   <= '0;
      bram_addr  <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_cnt   <= '0;
      done_q     <= 1'b0;
      for (int i = 0; i < 4; i++) fifo_mem[i] <= '0;
    end else begin
      done_q <= ((state == IDLE) && start && (len == '0)) || last_hs;
      // Tag stage 0: address on the RAM port; stage 1: bram_dout holds that word.
      tag_pipe <= {tag_pipe[0], issue};

      if (start_ok) begin
        base_q     <= base_addr;
        len_q      <= len;
        issued_cnt <= ONE;
        out_cnt    <= '0;
        credits    <= CREDITS_INIT - 3'd1;
        bram_addr  <= base_addr;
      end else begin
        if (issue) begin
          issued_cnt <= issued_cnt + ONE;
          bram_addr  <= base_q + issued_cnt[ADDR_WIDTH-1:0];
        end
        if (hs) out_cnt <= out_cnt + ONE;
        case ({issue, hs})
          2'b10:   credits <= credits - 3'd1;
          2'b01:   credits <= credits + 3'd1;
          default: credits <= credits;
        endcase
      end

      if (fifo_wr) begin
        fifo_mem[wr_ptr] <= bram_dout;
        wr_ptr           <= wr_ptr + 2'd1;
      end
      if (hs) rd_ptr <= rd_ptr + 2'd1;
      fifo_cnt <= fifo_cnt + {2'b00, fifo_wr} - {2'b00, hs};
    end
  end

endmodule

// File: tb/tb_bram_stream_reader.sv
// Directed bench for bram_stream_reader with a read-first RAM model (mem[i]=i+100).
module tb_bram_stream_reader;
  localparam int DW = 72;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   len;
  logic          busy, done;
  logic [AW-1:0] bram_addr;
  logic          bram_wr;
  logic [DW-1:0] bram_din, bram_dout, m_tdata;
  logic          m_tvalid, m_tready, m_tlast;

  bram_stream_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .len(len),
    .busy(busy), .done(done), .bram_addr(bram_addr), .bram_wr(bram_wr),
    .bram_din(bram_din), .bram_dout(bram_dout), .m_tdata(m_tdata),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast)
  );

  // clock / reset block
  always #5 clk = ~clk;

  logic [DW-1:0] ram [16];
  always @(posedge clk) bram_dout <= ram[bram_addr];

  int n_checks = 0;
  int n_errors = 0;

  // scoreboard state
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] got_data[$];
  logic          got_last[$];
  int            got_slot[$];
  logic [AW-1:0] addr_q[$];
  int            done_slot, done_cnt, stall_err, valid_seen, busy_seen, credit_max;
  logic          busy_at1;

  int pat_tbl [6] = '{1, 0, 0, 1, 0, 1};

  // Drive a start pulse at a negedge; returns at slot 1 (the negedge after the start edge).
  task automatic do_start(input int b, input int l);
    start     = 1'b1;
    base_addr = AW'(b);
    len       = (AW+1)'(l);
    @(posedge clk);
    @(negedge clk);
  endtask

  // Runs slot by slot from slot 1, driving m_tready and recording beats/done/addresses.
  task automatic run_xfer(input int budget, input int pat, input int restart_slot);
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data  = '0;
    logic          prev_last  = 1'b0;
    logic          rdy;
    got_data.delete(); got_last.delete(); got_slot.delete(); addr_q.delete();
    done_slot = -1; done_cnt = 0; stall_err = 0; valid_seen = 0; busy_seen = 0;
    credit_max = 0; busy_at1 = 1'b0;
    for (int k = 1; k <= budget; k++) begin
      if (k == restart_slot) begin
        start = 1'b1; base_addr = '0; len = 3;
      end else start = 1'b0;
      if (prev_stall && (!m_tvalid || m_tdata !== prev_data || m_tlast !== prev_last))
        stall_err++;
      if (done) begin
        done_cnt++;
        if (done_slot < 0) done_slot = k;
      end
      if (k == 1) busy_at1 = busy;
      if (busy) busy_seen++;
      if (m_tvalid) valid_seen++;
      if (int'(dut.credits) > credit_max) credit_max = int'(dut.credits);
      if (busy && (addr_q.size() == 0 || addr_q[$] != bram_addr)) addr_q.push_back(bram_addr);
      rdy = (pat == 0) ? 1'b1 : pat_tbl[(k-1) % 6][0];
      m_tready = rdy;
      if (m_tvalid && rdy) begin
        got_data.push_back(m_tdata); got_last.push_back(m_tlast); got_slot.push_back(k);
      end
      prev_stall = m_tvalid && !rdy;
      prev_data  = m_tdata;
      prev_last  = m_tlast;
      if (done_slot > 0 && k >= done_slot + 2) break;
      @(posedge clk);
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; base_addr = '0; len = '0; m_tready = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({busy, done, m_tvalid, m_tlast} !== 4'b0) begin
      n_errors++; $display("FAIL reset_ctrl: got %b want 0000", {busy, done, m_tvalid, m_tlast});
    end
    n_checks++;
    if (bram_addr !== '0 || m_tdata !== '0) begin
      n_errors++; $display("FAIL reset_data: addr %0d tdata %0d want 0 0", bram_addr, m_tdata);
    end
    n_checks++;
    if (bram_wr !== 1'b0 || bram_din !== '0) begin
      n_errors++; $display("FAIL reset_wr: wr %b din %0d want 0 0", bram_wr, bram_din);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    exp_q.delete();
    for (int i = 0; i < 4; i++) exp_q.push_back(DW'(102 + i));
    do_start(2, 4);
    run_xfer(40, 0, -1);
    n_checks++;
    if (busy_at1 !== 1'b1) begin n_errors++; $display("FAIL basic_busy: got %b want 1", busy_at1); end
    n_checks++;
    if (got_data.size() != 4) begin
      n_errors++; $display("FAIL basic_count: got %0d want 4", got_data.size());
    end
    for (int i = 0; i < 4 && i < got_data.size(); i++) begin
      n_checks++;
      if (got_data[i] !== exp_q[i] || got_slot[i] != 3 + i || got_last[i] !== (i == 3)) begin
        n_errors++;
        $display("FAIL basic_beat%0d: data %0d slot %0d last %b want %0d %0d %b",
                 i, got_data[i], got_slot[i], got_last[i], exp_q[i], 3 + i, i == 3);
      end
    end
    n_checks++;
    if (done_slot != 7 || done_cnt != 1) begin
      n_errors++; $display("FAIL basic_done: slot %0d cnt %0d want 7 1", done_slot, done_cnt);
    end
  endtask

  task automatic test_backpressure();
    exp_q.delete();
    for (int i = 0; i < 4; i++) exp_q.push_back(DW'(102 + i));
    do_start(2, 4);
    run_xfer(60, 1, -1);
    n_checks++;
    if (got_data.size() != 4) begin
      n_errors++; $display("FAIL bp_count: got %0d want 4", got_data.size());
    end
    for (int i = 0; i < 4 && i < got_data.size(); i++) begin
      n_checks++;
      if (got_data[i] !== exp_q[i] || got_last[i] !== (i == 3)) begin
        n_errors++;
        $display("FAIL bp_beat%0d: data %0d last %b want %0d %b", i, got_data[i], got_last[i], exp_q[i], i == 3);
      end
    end
    n_checks++;
    if (stall_err != 0) begin n_errors++; $display("FAIL bp_stable: got %0d violations want 0", stall_err); end
    n_checks++;
    if (credit_max > 4) begin n_errors++; $display("FAIL bp_credits: max %0d want <=4", credit_max); end
    n_checks++;
    if (done_cnt != 1) begin n_errors++; $display("FAIL bp_done: got %0d pulses want 1", done_cnt); end
  endtask

  task automatic test_wrap();
    logic [AW-1:0] exp_addr [4] = '{4'd14, 4'd15, 4'd0, 4'd1};
    exp_q.delete();
    exp_q.push_back(DW'(114)); exp_q.push_back(DW'(115));
    exp_q.push_back(DW'(100)); exp_q.push_back(DW'(101));
    do_start(14, 4);
    run_xfer(40, 0, -1);
    n_checks++;
    if (got_data.size() != 4 || addr_q.size() != 4) begin
      n_errors++; $display("FAIL wrap_count: beats %0d addrs %0d want 4 4", got_data.size(), addr_q.size());
    end
    for (int i = 0; i < 4 && i < got_data.size() && i < addr_q.size(); i++) begin
      n_checks++;
      if (got_data[i] !== exp_q[i] || addr_q[i] !== exp_addr[i]) begin
        n_errors++;
        $display("FAIL wrap_%0d: data %0d addr %0d want %0d %0d", i, got_data[i], addr_q[i], exp_q[i], exp_addr[i]);
      end
    end
  endtask

  task automatic test_len_zero();
    do_start(7, 0);
    run_xfer(10, 0, -1);
    n_checks++;
    if (valid_seen != 0 || busy_seen != 0) begin
      n_errors++; $display("FAIL len0_quiet: valid %0d busy %0d want 0 0", valid_seen, busy_seen);
    end
    n_checks++;
    if (done_slot != 1 || done_cnt != 1) begin
      n_errors++; $display("FAIL len0_done: slot %0d cnt %0d want 1 1", done_slot, done_cnt);
    end
  endtask

  task automatic test_full_depth();
    int bad = 0;
    exp_q.delete();
    for (int i = 0; i < 16; i++) exp_q.push_back(DW'(100 + ((5 + i) % 16)));
    do_start(5, 16);
    run_xfer(80, 0, -1);
    n_checks++;
    if (got_data.size() != 16 || addr_q.size() != 16) begin
      n_errors++; $display("FAIL full_count: beats %0d addrs %0d want 16 16", got_data.size(), addr_q.size());
    end
    for (int i = 0; i < 16 && i < got_data.size() && i < addr_q.size(); i++)
      if (got_data[i] !== exp_q[i] || int'(addr_q[i]) != (5 + i) % 16 || got_last[i] !== (i == 15)) bad++;
    n_checks++;
    if (bad != 0) begin n_errors++; $display("FAIL full_order: got %0d bad beats want 0", bad); end
    n_checks++;
    if (got_slot.size() != 16 || got_slot[$] != 18) begin
      n_errors++; $display("FAIL full_latency: last beat slot %0d want 18", got_slot.size() ? got_slot[$] : -1);
    end
  endtask

  task automatic test_start_while_busy();
    exp_q.delete();
    for (int i = 0; i < 4; i++) exp_q.push_back(DW'(102 + i));
    do_start(2, 4);
    run_xfer(60, 1, 4);
    n_checks++;
    if (got_data.size() != 4 || done_cnt != 1) begin
      n_errors++; $display("FAIL restart_count: beats %0d done %0d want 4 1", got_data.size(), done_cnt);
    end
    for (int i = 0; i < 4 && i < got_data.size(); i++) begin
      n_checks++;
      if (got_data[i] !== exp_q[i] || got_last[i] !== (i == 3)) begin
        n_errors++;
        $display("FAIL restart_beat%0d: data %0d last %b want %0d %b", i, got_data[i], got_last[i], exp_q[i], i == 3);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_start(2, 8);
    run_xfer(5, 0, -1);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({busy, done, m_tvalid, m_tlast} !== 4'b0 || bram_addr !== '0 || m_tdata !== '0) begin
      n_errors++;
      $display("FAIL midreset_outputs: ctrl %b addr %0d tdata %0d want 0000 0 0",
               {busy, done, m_tvalid, m_tlast}, bram_addr, m_tdata);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    exp_q.delete();
    for (int i = 0; i < 3; i++) exp_q.push_back(DW'(109 + i));
    do_start(9, 3);
    run_xfer(40, 0, -1);
    n_checks++;
    if (got_data.size() != 3 || done_slot != 6 || done_cnt != 1) begin
      n_errors++;
      $display("FAIL midreset_after: beats %0d done_slot %0d cnt %0d want 3 6 1", got_data.size(), done_slot, done_cnt);
    end
    for (int i = 0; i < 3 && i < got_data.size(); i++) begin
      n_checks++;
      if (got_data[i] !== exp_q[i] || got_slot[i] != 3 + i || got_last[i] !== (i == 2)) begin
        n_errors++;
        $display("FAIL midreset_beat%0d: data %0d slot %0d last %b want %0d %0d %b",
                 i, got_data[i], got_slot[i], got_last[i], exp_q[i], 3 + i, i == 2);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) ram[i] = DW'(100 + i);
    test_reset();
    test_basic();
    test_backpressure();
    test_wrap();
    test_len_zero();
    test_full_depth();
    test_start_while_busy();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/bram_stream_reader.md
Name: bram_stream_reader

Overview:
- Read-side master for one port of the team's synchronous dual-port block RAM.
- The RAM has one-cycle read latency, read-first behaviour, and no read enable.
- On a start pulse, the block reads a contiguous run of LEN words from BASE and emits them on a valid/ready stream with backpressure.
- Typical use: readout of capture/snapshot buffers filled through the other RAM port.

Parameters:
- DATA_WIDTH, 72, width of RAM words and stream data.
- ADDR_WIDTH, 10, RAM address width; RAM depth is 2**ADDR_WIDTH.

Ports:
- clk  in  1  single clock; RAM port and stream share it.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request pulse; sampled only when busy=0.
- base_addr  in  ADDR_WIDTH  first word address; sampled with start.
- len  in  ADDR_WIDTH+1  number of words; range 0..2**ADDR_WIDTH; sampled with start.
- busy  out  1  transfer in progress.
- done  out  1  one-cycle pulse at the end of a transfer.
- bram_addr  out  ADDR_WIDTH  registered address to the RAM port.
- bram_wr  out  1  constant 0; this block never writes.
- bram_din  out  DATA_WIDTH  constant 0.
- bram_dout  in  DATA_WIDTH  RAM read data; valid one cycle after bram_addr.
- m_tdata  out  DATA_WIDTH  stream data.
- m_tvalid  out  1  stream valid.
- m_tready  in  1  stream ready.
- m_tlast  out  1  marks the final word of a transfer.

Behaviour:
- Reset (async, rst_n=0):
  - busy=0, done=0, m_tvalid=0, m_tlast=0, bram_addr=0, m_tdata=0.
  - All counters, the pipeline and the buffer are cleared.
  - The block leaves reset in IDLE.
- Reset mid-transfer: the transfer is abandoned, with no done and no further beats. The beat on the bus is dropped with no handshake.
- State IDLE:
  - start=1 and len>0: latch base_addr and len, go to RUN, busy=1 from the next cycle.
  - start=1 and len=0: done=1 for exactly one cycle after the start edge; busy stays 0.
- State RUN:
  - Issue side:
    - A read issues in a cycle when issued_count < len and credits > 0.
    - Issuing drives bram_addr = latched base + issued_count, modulo 2**ADDR_WIDTH.
    - Addresses wrap from 2**ADDR_WIDTH-1 to 0.
    - bram_addr holds its last value when not issuing.
  - Pipeline:
    - A valid-tag pipeline of 2 stages tracks the issued address and then the RAM output.
    - The word returned for an issued address is written into an internal 4-entry FIFO on the edge 2 cycles after the issue edge.
  - Credits:
    - Credit counter starts at 4 at start.
    - Decrements on issue and increments on a stream handshake (m_tvalid & m_tready).
    - Simultaneous issue and handshake leave it unchanged.
    - The FIFO never overflows; reaching capacity is legal.
  - Stream side:
    - m_tvalid = FIFO not empty; m_tdata = FIFO head, registered.
    - m_tdata and m_tlast stay stable while m_tvalid=1 and m_tready=0.
    - m_tlast=1 exactly on the word whose index equals len-1.
  - Completion:
    - Go to IDLE on the handshake of the m_tlast word.
    - busy=0 and done=1 in the following cycle.
    - start is ignored while busy=1.
- Latency: with start sampled at edge E0, bram_addr=base after E0, and the first m_tvalid is visible after E2.
- Throughput: with m_tready held high, the block sustains 1 word/cycle, so len words take len+2 cycles from start to the last beat.
- len=2**ADDR_WIDTH reads every word exactly once, starting at base.
- Output order is strictly ascending address (with wrap); data is never duplicated or skipped.

Test Plan:
- ADDR_WIDTH=4, RAM preloaded mem[i]=i+100, base=2, len=4, tready=1:
  - Beats 102,103,104,105 on consecutive cycles, first valid 2 cycles after the start edge.
  - tlast on 105; done 1 cycle later.
- Same setup with tready toggling 1,0,0,1,0,1,…:
  - The same 4 words in order, with no loss or duplication.
  - Data/last stable during stalls; the credit counter never underflows.
- Wrap: base=14, len=4:
  - Beats 114,115,100,101; bram_addr sequence 14,15,0,1.
- len=0:
  - No m_tvalid; done pulses once, 1 cycle after start; busy stays 0.
- Full depth: len=16, base=5, tready=1:
  - 16 beats, all addresses covered once, 18 cycles from start to last beat.
- Control and reset:
  - start pulsed again during busy with base=0 is ignored; the original transfer completes unchanged.
  - rst_n low mid-transfer forces all outputs to reset values immediately.
  - A subsequent start runs a clean new transfer.
